// File: rtl/arith_test_pkg.sv
// Shared constants for the arithmetic test controller: bus offsets,
// op-codes, FSM state type and the Galois LFSR tap selection.
package arith_test_pkg;

  localparam logic [3:0] ADDR_OP_A   = 4'h0;
  localparam logic [3:0] ADDR_OP_B   = 4'h4;
  localparam logic [3:0] ADDR_RESULT = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Maximal-length Galois taps for the supported operand widths
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/arith_test_controller_lfsr_gen.sv
// Galois right-shift LFSR operand generator. Loads its seed on reset or
// load, advances one step whenever step is high. A zero seed becomes 1 so
// the register can never lock up.
module lfsr_gen
  import arith_test_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0]      TAPS32   = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_T   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_T == '0) ? WIDTH'(1) : SEED_T;

  // Seed on reset/load, otherwise shift right and fold taps in on a 1 out
  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/arith_test_controller.sv
// Avalon-MM test controller for arithmetic units. Runs one operation on
// software operands or an N-iteration soak on LFSR operands, folding every
// result into an XOR signature. Optional macro ARITH_TEST_CTRL_MUL_EN turns
// op-code 11 into a single-cycle multiply; otherwise 11 behaves as xor.
module arith_test_controller
  import arith_test_pkg::*;
#(
  parameter int          WIDTH  = 32,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED_A = 32'h0000_FFFF,
  parameter logic [31:0] SEED_B = 32'hACE1_ACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       slave_address,
  input  logic             slave_read,
  input  logic             slave_write,
  input  logic [WIDTH-1:0] slave_writedata,
  output logic [WIDTH-1:0] slave_readdata,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_b_q, result_q;
  logic [CNT_W-1:0]   cnt_q, n_q, cnt_inc, n_in;
  logic [1:0]         op_q;
  logic               rand_q, done_q, ovf_q;
  logic [WIDTH-1:0]   lfsr_a, lfsr_b, opnd_a, opnd_b;
  logic [WIDTH:0]     op_res;
  logic [WIDTH-1:0]   status_word, rd_mux;
  logic               wr, rd, ctrl_wr, start_req, start_zero, clr_req;
  logic               in_run, last_iter;

  // Returns {ovf, result}: carry on add, borrow on sub, high product bits on mul
  function automatic logic [WIDTH:0] apply_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
`ifdef ARITH_TEST_CTRL_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
`ifdef ARITH_TEST_CTRL_MUL_EN
      OP_MUL: begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      end
`endif
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // A simultaneous read and write is treated as no access at all
  assign wr         = slave_write & ~slave_read;
  assign rd         = slave_read & ~slave_write;
  assign ctrl_wr    = wr && (slave_address == ADDR_CTRL);
  assign n_in       = slave_writedata[16 +: CNT_W];
  assign in_run     = (state_q == ST_RUN);
  assign start_req  = ctrl_wr && slave_writedata[0] && !in_run;
  assign start_zero = slave_writedata[1] && (n_in == '0);
  assign clr_req    = ctrl_wr && slave_writedata[4];
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign last_iter  = !rand_q || (cnt_inc == n_q);

  assign opnd_a = rand_q ? lfsr_a : op_a_q;
  assign opnd_b = rand_q ? lfsr_b : op_b_q;
  assign op_res = apply_op(op_q, opnd_a, opnd_b);

  lfsr_gen #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
    .clk(clk), .reset(reset), .load(start_req), .step(in_run), .q(lfsr_a)
  );

  lfsr_gen #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .reset(reset), .load(start_req), .step(in_run), .q(lfsr_b)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: START leaves IDLE unless it is a zero-length soak
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req && !start_zero) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Operand registers, run setup, signature accumulation and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      op_q     <= OP_ADD;
      rand_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr && slave_address == ADDR_OP_A) op_a_q <= slave_writedata;
      if (wr && slave_address == ADDR_OP_B) op_b_q <= slave_writedata;
      if (start_req) begin
        op_q     <= slave_writedata[3:2];
        rand_q   <= slave_writedata[1];
        n_q      <= n_in;
        result_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        done_q   <= start_zero;
      end else if (in_run) begin
        result_q <= result_q ^ op_res[WIDTH-1:0];
        cnt_q    <= cnt_inc;
        ovf_q    <= (ovf_q & ~clr_req) | op_res[WIDTH];
        if (last_iter) done_q <= 1'b1;
      end else if (clr_req) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
    end
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    status_word               = '0;
    status_word[0]            = busy;
    status_word[1]            = done_q;
    status_word[2]            = ovf_q;
    status_word[16 +: CNT_W]  = cnt_q;
    case (slave_address)
      ADDR_OP_A:   rd_mux = op_a_q;
      ADDR_OP_B:   rd_mux = op_b_q;
      ADDR_RESULT: rd_mux = result_q;
      ADDR_CTRL:   rd_mux = status_word;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data, held when no clean read is presented
  always_ff @(posedge clk) begin
    if (reset)   slave_readdata <= '0;
    else if (rd) slave_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_arith_test_controller.sv
// Directed + randomized bench for arith_test_controller (WIDTH=32, CNT_W=16).
module tb_arith_test_controller;

  localparam logic [3:0] A_OPA = 4'h0;
  localparam logic [3:0] A_OPB = 4'h4;
  localparam logic [3:0] A_RES = 4'h8;
  localparam logic [3:0] A_CTL = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_writedata, slave_readdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  arith_test_controller dut (
    .clk(clk), .reset(reset), .slave_address(slave_address),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $display("FAIL %s: observed=%h required=%h", tag, obs, exp_v);
      $error("check %s: observed=%h required=%h", tag, obs, exp_v);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  // Issue a CTRL write and count the busy cycles that follow (bounded)
  task automatic run_ctrl(input logic [31:0] ctrl, output int cyc);
    bus_wr(A_CTL, ctrl);
    cyc = 0;
    while (busy && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference operation: returns {ovf, result}
  function automatic logic [32:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      0: begin r = a + b; v = (r < a); end
      1: begin r = a - b; v = (a < b); end
`ifdef ARITH_TEST_CTRL_MUL_EN
      3: begin r = p[31:0]; v = (p >= 64'h1_0000_0000); end
`endif
      default: begin r = a ^ b; v = 1'b0; end
    endcase
    return {v, r};
  endfunction

  // Reference soak: reseeded LFSRs, N iterations folded into an XOR signature
  function automatic logic [32:0] ref_soak(input int op, input int n);
    logic [31:0] la, lb, sig;
    logic        v;
    logic [32:0] t;
    la = 32'h0000_FFFF; lb = 32'hACE1_ACE1; sig = '0; v = 1'b0;
    for (int i = 0; i < n; i++) begin
      t   = ref_op(op, la, lb);
      sig = sig ^ t[31:0];
      v   = v | t[32];
      la  = lfsr_next(la);
      lb  = lfsr_next(lb);
    end
    return {v, sig};
  endfunction

  initial begin
    logic [31:0] d, a, b, held;
    logic [32:0] m;
    int          cyc, op, n;

    reset = 1'b1; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", {31'b0, busy}, 32'h0);
    bus_rd(A_CTL, d); check("rst_status", d, 32'h0);
    bus_rd(A_RES, d); check("rst_result", d, 32'h0);
    bus_rd(A_OPA, d); check("rst_opa", d, 32'h0);

    // Single add
    bus_wr(A_OPA, 32'd5); bus_wr(A_OPB, 32'd7);
    run_ctrl(32'h1, cyc); check("add_busy_cycles", cyc, 1);
    bus_rd(A_RES, d); check("add_result", d, 32'd12);
    bus_rd(A_CTL, d); check("add_status", d, 32'h0001_0002);

    // Single sub with borrow, then CLR
    bus_wr(A_OPA, 32'd3); bus_wr(A_OPB, 32'd5);
    run_ctrl(32'h5, cyc); check("sub_busy_cycles", cyc, 1);
    bus_rd(A_RES, d); check("sub_result", d, 32'hFFFF_FFFE);
    bus_rd(A_CTL, d); check("sub_status_ovf", d, 32'h0001_0006);
    bus_wr(A_CTL, 32'h10);
    bus_rd(A_CTL, d); check("clr_status", d & 32'h6, 32'h0);

    // Random add, N=1
    run_ctrl(32'h0001_0003, cyc); check("r1_busy_cycles", cyc, 1);
    bus_rd(A_RES, d); check("r1_result", d, 32'hACE2_ACE0);
    bus_rd(A_CTL, d); check("r1_status", d, 32'h0001_0002);

    // Random N=0: never busy, done, empty signature
    run_ctrl(32'h3, cyc); check("r0_busy_cycles", cyc, 0);
    bus_rd(A_RES, d); check("r0_result", d, 32'h0);
    bus_rd(A_CTL, d); check("r0_status", d, 32'h2);

    // Randomized single-mode operations
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; op = $urandom_range(0, 3);
      if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h1; op = 0; end
      bus_wr(A_OPA, a); bus_wr(A_OPB, b);
      m = ref_op(op, a, b);
      run_ctrl(32'(op << 2) | 32'h1, cyc);
      check("single_busy_cycles", cyc, 1);
      bus_rd(A_RES, d); check("single_result", d, m[31:0]);
      bus_rd(A_CTL, d); check("single_status", d, 32'h0001_0002 | (m[32] ? 32'h4 : 32'h0));
    end

    // Randomized soaks
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(1, 40); op = $urandom_range(0, 3);
      m = ref_soak(op, n);
      run_ctrl(32'(n << 16) | 32'(op << 2) | 32'h3, cyc);
      check("soak_busy_cycles", cyc, n);
      bus_rd(A_RES, d); check("soak_result", d, m[31:0]);
      bus_rd(A_CTL, d); check("soak_status", d, 32'(n << 16) | 32'h2 | (m[32] ? 32'h4 : 32'h0));
    end

    // xor soak of 1000 with an ignored START written mid-run
    m = ref_soak(2, 1000);
    bus_wr(A_CTL, 32'h03E8_000B);
    cyc = 0;
    while (busy && cyc < 4000) begin
      if (cyc == 100) begin
        slave_address = A_CTL; slave_writedata = 32'h1; slave_write = 1'b1;
      end else begin
        slave_write = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    slave_write = 1'b0;
    check("x1000_busy_cycles", cyc, 1000);
    bus_rd(A_RES, d); check("x1000_result", d, m[31:0]);
    bus_rd(A_CTL, d); check("x1000_status", d, 32'h03E8_0002);

    // Bus edge cases
    bus_rd(4'h3, d); check("unmapped_read", d, 32'h0);
    bus_wr(A_OPA, 32'h1234_5678);
    bus_rd(A_RES, held);
    slave_address = A_OPA; slave_writedata = 32'hDEAD_BEEF;
    slave_read = 1'b1; slave_write = 1'b1;
    @(negedge clk);
    slave_read = 1'b0; slave_write = 1'b0;
    check("rw_readdata_held", slave_readdata, held);
    bus_rd(A_OPA, d); check("rw_opa_unchanged", d, 32'h1234_5678);

    // Op-code 11: multiply when enabled, xor otherwise
    bus_wr(A_OPA, 32'h0001_0000); bus_wr(A_OPB, 32'h0001_0000);
    run_ctrl(32'hD, cyc); check("op11_busy_cycles", cyc, 1);
    bus_rd(A_RES, d); check("op11_result", d, 32'h0);
`ifdef ARITH_TEST_CTRL_MUL_EN
    bus_rd(A_CTL, d); check("op11_status", d, 32'h0001_0006);
`else
    bus_rd(A_CTL, d); check("op11_status", d, 32'h0001_0002);
`endif

    // Reset pulsed halfway through a long soak discards everything
    bus_wr(A_CTL, 32'h03E8_000B);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    check("mid_busy_cycles", cyc, 500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    bus_rd(A_CTL, d); check("mid_rst_status", d, 32'h0);
    bus_rd(A_RES, d); check("mid_rst_result", d, 32'h0);
    bus_rd(A_OPA, d); check("mid_rst_opa", d, 32'h0);
    repeat (3) @(negedge clk);
    check("mid_rst_stays_idle", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
